// File: rtl/btn_event_ctrl.sv
// Push-button front end: per-button synchroniser and debouncer, hold/auto-repeat FSM,
// and a round-robin arbiter that serialises press/repeat events onto one valid/ready port.
module btn_event_ctrl #(
    parameter int N             = 4,
    parameter int IDW           = 2,
    parameter int DEB_CYCLES    = 1000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   btn,
    output logic [N-1:0]   btn_level,
    output logic           evt_valid,
    output logic [IDW-1:0] evt_id,
    output logic           evt_repeat,
    input  logic           evt_ready
);

    localparam int DW   = $clog2(DEB_CYCLES);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX);

    localparam logic [DW-1:0]  DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0]  HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]  RPT_LAST  = TW'(REPEAT_CYCLES - 1);
    localparam logic [IDW-1:0] ID_LAST   = IDW'(N - 1);
    localparam logic [IDW:0]   N_W       = (IDW + 1)'(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } state_t;

    logic [N-1:0]   r_sync1;
    logic [N-1:0]   r_sync2;
    logic [DW-1:0]  r_deb_cnt [N];
    state_t         r_state   [N];
    logic [TW-1:0]  r_timer   [N];
    logic [N-1:0]   r_pend;
    logic [N-1:0]   r_pend_rpt;
    logic [IDW-1:0] r_ptr;

    logic [N-1:0]   w_raise;
    logic [N-1:0]   w_new_rpt;
    logic           w_load;
    logic           w_found;
    logic [IDW-1:0] w_sel;
    logic [IDW:0]   w_cand;
    logic [N-1:0]   w_clr;

    // Two-flop synchroniser and per-bit debounce counter driving btn_level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            btn_level <= '0;
            for (int i = 0; i < N; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            for (int i = 0; i < N; i++) begin
                if (r_sync2[i] == btn_level[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    btn_level[i] <= ~btn_level[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Event raise decode from the current FSM state, timer and debounced level.
    always_comb begin
        w_raise   = '0;
        w_new_rpt = '0;
        for (int i = 0; i < N; i++) begin
            case (r_state[i])
                ST_IDLE: begin
                    w_raise[i] = btn_level[i];
                end
                ST_HOLD: begin
                    if (btn_level[i] && (r_timer[i] == HOLD_LAST)) begin
                        w_raise[i]   = 1'b1;
                        w_new_rpt[i] = 1'b1;
                    end else begin
                        w_raise[i]   = 1'b0;
                    end
                end
                ST_RPT: begin
                    if (btn_level[i] && (r_timer[i] == RPT_LAST)) begin
                        w_raise[i]   = 1'b1;
                        w_new_rpt[i] = 1'b1;
                    end else begin
                        w_raise[i]   = 1'b0;
                    end
                end
                default: begin
                    w_raise[i] = 1'b0;
                end
            endcase
        end
    end

    // Per-button hold/auto-repeat state machine and its timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= ST_IDLE;
                r_timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                case (r_state[i])
                    ST_IDLE: begin
                        r_timer[i] <= '0;
                        if (btn_level[i]) begin
                            r_state[i] <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (!btn_level[i]) begin
                            r_state[i] <= ST_IDLE;
                            r_timer[i] <= '0;
                        end else if (r_timer[i] == HOLD_LAST) begin
                            r_state[i] <= ST_RPT;
                            r_timer[i] <= '0;
                        end else begin
                            r_timer[i] <= r_timer[i] + TW'(1);
                        end
                    end
                    ST_RPT: begin
                        if (!btn_level[i]) begin
                            r_state[i] <= ST_IDLE;
                            r_timer[i] <= '0;
                        end else if (r_timer[i] == RPT_LAST) begin
                            r_timer[i] <= '0;
                        end else begin
                            r_timer[i] <= r_timer[i] + TW'(1);
                        end
                    end
                    default: begin
                        r_state[i] <= ST_IDLE;
                        r_timer[i] <= '0;
                    end
                endcase
            end
        end
    end

    // Round-robin pick: first pending bit at or after the pointer, wrapping at N-1.
    always_comb begin
        w_load  = !evt_valid || evt_ready;
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = {1'b0, r_ptr} + (IDW + 1)'(i);
            if (w_cand >= N_W) begin
                w_cand = w_cand - N_W;
            end else begin
                w_cand = w_cand;
            end
            if (!w_found && r_pend[w_cand[IDW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[IDW-1:0];
            end else begin
                w_found = w_found;
            end
        end
        if (w_load && w_found) begin
            w_clr = N'(1) << w_sel;
        end else begin
            w_clr = '0;
        end
    end

    // Pending store; a new raise beats a same-cycle grant, and a press is never demoted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= '0;
            r_pend_rpt <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_raise[i]) begin
                    r_pend[i] <= 1'b1;
                    if (r_pend[i] && !w_clr[i]) begin
                        r_pend_rpt[i] <= r_pend_rpt[i] & w_new_rpt[i];
                    end else begin
                        r_pend_rpt[i] <= w_new_rpt[i];
                    end
                end else if (w_clr[i]) begin
                    r_pend[i] <= 1'b0;
                end else begin
                    r_pend[i] <= r_pend[i];
                end
            end
        end
    end

    // Output event register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            evt_repeat <= 1'b0;
            r_ptr      <= '0;
        end else if (w_load) begin
            if (w_found) begin
                evt_valid  <= 1'b1;
                evt_id     <= w_sel;
                evt_repeat <= r_pend_rpt[w_sel];
                r_ptr      <= (w_sel == ID_LAST) ? '0 : (w_sel + IDW'(1));
            end else begin
                evt_valid  <= 1'b0;
            end
        end else begin
            evt_valid <= evt_valid;
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: directed scenarios plus randomized stimulus, all compared
// every cycle against a behavioural model based on press age and pending flags.
module tb_btn_event_ctrl;

    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int RPT  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   btn;
    logic [N-1:0]   btn_level;
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic           evt_repeat;
    logic           evt_ready;

    btn_event_ctrl #(
        .N(N), .IDW(IDW), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .btn_level(btn_level),
        .evt_valid(evt_valid), .evt_id(evt_id), .evt_repeat(evt_repeat),
        .evt_ready(evt_ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    // Reference model state: debounce run length, press age, pending flags, output.
    bit [N-1:0] m_s1, m_s2, m_lvl, m_pend, m_prt;
    int         m_run [N];
    bit         m_act [N];
    int         m_age [N];
    int         m_ptr, m_id;
    bit         m_valid, m_rep;

    task automatic model_edge(input bit [N-1:0] b, input bit rdy, input bit r);
        bit [N-1:0] raise, nrpt, pend_c;
        bit found;
        int sel, idx;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0; m_prt = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0; m_act[i] = 0; m_age[i] = 0;
            end
            m_ptr = 0; m_id = 0; m_valid = 0; m_rep = 0;
            return;
        end
        raise = '0; nrpt = '0;
        for (int i = 0; i < N; i++) begin
            if (!m_act[i]) begin
                if (m_lvl[i]) begin
                    raise[i] = 1; m_act[i] = 1; m_age[i] = 0;
                end
            end else if (!m_lvl[i]) begin
                m_act[i] = 0;
            end else begin
                m_age[i]++;
                if (m_age[i] >= HOLD && ((m_age[i] - HOLD) % RPT) == 0) begin
                    raise[i] = 1; nrpt[i] = 1;
                end
            end
        end
        pend_c = m_pend;
        if (!m_valid || rdy) begin
            found = 0; sel = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && m_pend[idx]) begin
                    found = 1; sel = idx;
                end
            end
            if (found) begin
                m_valid = 1; m_id = sel; m_rep = m_prt[sel];
                pend_c[sel] = 0; m_ptr = (sel + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (raise[i]) begin
                m_prt[i]  = pend_c[i] ? (m_prt[i] & nrpt[i]) : nrpt[i];
                pend_c[i] = 1;
            end
        end
        m_pend = pend_c;
        for (int i = 0; i < N; i++) begin
            if (m_s2[i] == m_lvl[i]) m_run[i] = 0;
            else if (m_run[i] + 1 == DEB) begin
                m_lvl[i] = ~m_lvl[i]; m_run[i] = 0;
            end else m_run[i]++;
        end
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic tick(input bit [N-1:0] b, input bit rdy, input bit r);
        btn = b; evt_ready = rdy; rst = r;
        @(posedge clk);
        model_edge(b, rdy, r);
        #1;
        check("btn_level", int'(btn_level), int'(m_lvl));
        check("evt_valid", int'(evt_valid), int'(m_valid));
        check("evt_id", int'(evt_id), m_id);
        check("evt_repeat", int'(evt_repeat), int'(m_rep));
    endtask

    int lvl_rise, ev_cnt, ev_at, ev_id, ev_rep, rpt_cnt, rpt1, rpt2, rose;
    bit [N-1:0] tgt, rb;

    initial begin
        btn = '0; evt_ready = 1'b1; rst = 1'b1;
        repeat (3) tick('0, 1, 1);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_level", int'(btn_level), 0);
        repeat (2) tick('0, 1, 0);

        // Clean press on button 2
        lvl_rise = -1; ev_cnt = 0; ev_at = -1; ev_id = -1; ev_rep = -1;
        for (int k = 0; k < 30; k++) begin
            tick((k < 10) ? 4'b0100 : 4'b0000, 1, 0);
            if (lvl_rise < 0 && btn_level[2]) lvl_rise = k;
            if (evt_valid) begin
                ev_cnt++;
                if (ev_at < 0) begin ev_at = k; ev_id = evt_id; ev_rep = evt_repeat; end
            end
        end
        check("press_lvl_edge", lvl_rise, 5);
        check("press_evt_edge", ev_at, 7);
        check("press_evt_id", ev_id, 2);
        check("press_evt_rep", ev_rep, 0);
        check("press_evt_cnt", ev_cnt, 1);

        // Glitches of 3 and 4 cycles on button 0
        for (int glen = 3; glen <= 4; glen++) begin
            rose = 0; ev_cnt = 0;
            for (int k = 0; k < 20; k++) begin
                tick((k < glen) ? 4'b0001 : 4'b0000, 1, 0);
                if (btn_level[0]) rose = 1;
                if (evt_valid) ev_cnt++;
            end
            check("glitch_lvl", rose, (glen == 4) ? 1 : 0);
            check("glitch_evts", ev_cnt, (glen == 4) ? 1 : 0);
        end

        // Auto-repeat on button 1
        ev_at = -1; ev_cnt = 0; rpt_cnt = 0; rpt1 = -1; rpt2 = -1;
        for (int k = 0; k < 90; k++) begin
            tick((k < 65) ? 4'b0010 : 4'b0000, 1, 0);
            if (evt_valid && !evt_repeat) begin ev_cnt++; ev_at = k; end
            if (evt_valid && evt_repeat) begin
                rpt_cnt++;
                if (rpt1 < 0) rpt1 = k;
                else if (rpt2 < 0) rpt2 = k;
            end
        end
        check("rpt_press_cnt", ev_cnt, 1);
        check("rpt_first_gap", rpt1 - ev_at, HOLD);
        check("rpt_period", rpt2 - rpt1, RPT);
        check("rpt_cnt", rpt_cnt, 6);

        // Fairness and backpressure: all buttons at once
        tick('0, 1, 1);
        ev_at = -1;
        for (int k = 0; k < 20 && ev_at < 0; k++) begin
            tick(4'b1111, 0, 0);
            if (evt_valid) ev_at = k;
        end
        check("fair_first_edge", ev_at, 7);
        check("fair_first_id", int'(evt_id), 0);
        for (int k = 0; k < 5; k++) begin
            tick(4'b1111, 0, 0);
            check("fair_hold_id", int'(evt_id), 0);
            check("fair_hold_valid", int'(evt_valid), 1);
        end
        for (int k = 1; k < N; k++) begin
            tick(4'b1111, 1, 0);
            check("fair_seq_id", int'(evt_id), k);
        end
        tick(4'b0000, 1, 0);
        check("fair_drained", int'(evt_valid), 0);
        repeat (15) tick('0, 1, 0);

        // Merge of press and repeat for button 3 while the output is blocked
        tick('0, 1, 1);
        ev_at = -1;
        for (int k = 0; k < 20 && ev_at < 0; k++) begin
            tick(4'b0001, 0, 0);
            if (evt_valid) ev_at = k;
        end
        check("merge_blocker", ev_at, 7);
        repeat (35) tick(4'b1001, 0, 0);
        tick(4'b1001, 1, 0);
        check("merge_id", int'(evt_id), 3);
        check("merge_rep", int'(evt_repeat), 0);
        tick(4'b1001, 1, 0);
        check("merge_next_id", int'(evt_id), 0);
        check("merge_next_rep", int'(evt_repeat), 1);
        repeat (20) tick('0, 1, 0);

        // Reset while in auto-repeat with a pending event
        repeat (40) tick(4'b0010, 0, 0);
        tick(4'b0010, 1, 1);
        check("midrst_valid", int'(evt_valid), 0);
        check("midrst_level", int'(btn_level), 0);
        check("midrst_id", int'(evt_id), 0);
        ev_at = -1; ev_rep = -1;
        for (int k = 0; k < 20 && ev_at < 0; k++) begin
            tick(4'b0010, 1, 0);
            if (evt_valid) begin ev_at = k; ev_rep = evt_repeat; end
        end
        check("midrst_evt_edge", ev_at, 1 + DEB + 2);
        check("midrst_evt_rep", ev_rep, 0);
        repeat (20) tick('0, 1, 0);

        // Randomized buttons with glitches, random ready and rare resets
        tgt = '0;
        for (int k = 0; k < 3000; k++) begin
            rb = tgt;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 39) == 0) tgt[i] = ~tgt[i];
                rb[i] = tgt[i];
                if ($urandom_range(0, 29) == 0) rb[i] = ~tgt[i];
            end
            tick(rb, $urandom_range(0, 3) != 0, $urandom_range(0, 999) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
- Front-end controller for the board push-buttons. It synchronises and debounces N raw buttons with per-button counters.
- A per-button hold/auto-repeat state machine turns each press into discrete events.
- A round-robin arbiter serialises pending events onto one valid/ready event port consumed by the convolution control logic.
- It replaces ad-hoc per-button debounce plus edge-sample chains with one scheduled source of press/repeat events.

Parameters:
- N, 4, number of buttons (1..16).
- IDW, 2, width of evt_id; must satisfy 2^IDW >= N.
- DEB_CYCLES, 1000, consecutive stable synchronised cycles required to change a debounced level (>=2).
- HOLD_CYCLES, 50000000, cycles a level must stay high before the first repeat event (>=2).
- REPEAT_CYCLES, 10000000, cycles between subsequent repeat events (>=2).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous reset, active-high.
- btn  in  N  raw asynchronous button inputs, active-high.
- btn_level  out  N  debounced button levels.
- evt_valid  out  1  event available.
- evt_id  out  IDW  index of the button that produced the event.
- evt_repeat  out  1  0 = initial press, 1 = auto-repeat.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready at a rising edge.

Behaviour:
- Reset (rst high at a clk edge): clears sync flops, btn_level, debounce counters, FSMs (IDLE), timers, pending bits, round-robin pointer (0), evt_valid, evt_id and evt_repeat to 0. Reset mid-hold discards all pending events and in-flight timers. After reset, a button already held high re-debounces from 0 and produces a fresh press event.
- Sync: two flops per bit; s2 is the synchronised value.
- Debounce, per bit:
  - Counter clears in any cycle where s2 == btn_level.
  - Otherwise it increments. When it reaches DEB_CYCLES-1, btn_level toggles at that edge and the counter clears.
  - Net: a clean btn change seen at edge 0 moves btn_level at edge 1+DEB_CYCLES. Glitches shorter than DEB_CYCLES never move it.
- Per-button FSM, states IDLE / HOLD / RPT, with timer width ceil(log2(max(HOLD_CYCLES,REPEAT_CYCLES))):
  - IDLE & btn_level=1 -> HOLD, timer=0, raise press event.
  - HOLD: timer++. When timer==HOLD_CYCLES-1 -> RPT, timer=0, raise repeat event.
  - RPT: timer++. When timer==REPEAT_CYCLES-1 -> timer=0, raise repeat event (stay RPT).
  - HOLD/RPT & btn_level=0 -> IDLE, timer=0. No release event. Already-pending events are kept.
- Pending store: per button, pend and pend_rpt. Raising an event sets pend.
  - If pend is already set, events merge (no counting). pend_rpt becomes pend_rpt AND new_rpt, so a press is never demoted to a repeat.
  - If an event is raised in the same cycle that the arbiter clears that bit, the set wins: pend stays 1, pend_rpt = new_rpt.
- Arbiter / output register:
  - Load condition: !evt_valid || evt_ready.
  - When the load condition holds and any pend is set, select the first set bit scanning from ptr upward with wrap at N-1 -> 0.
  - Register evt_valid=1, evt_id=idx, evt_repeat=pend_rpt[idx]. Clear pend[idx]. Set ptr=(idx+1) mod N.
  - When the load condition holds and no pend is set, evt_valid <= 0.
  - While evt_valid && !evt_ready, outputs hold stable and no pend bits are cleared.
  - Throughput is 1 event/cycle under continuous ready.
- Latency: btn_level rising at edge D gives pend at D+1 and evt_valid at D+2, when the output stage is free.

Test Plan (N=4, IDW=2, DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, evt_ready=1 unless stated):
- Clean press btn[2] high at edge 0, held 10 cycles -> btn_level[2] rises at edge 5. Exactly one event at edge 7: evt_id=2, evt_repeat=0, valid for one cycle.
- Glitch: btn[0] high for 3 cycles, then low -> btn_level[0] never rises, no event. Same at 4 cycles -> btn_level rises.
- Auto-repeat: hold btn[1] for 60 cycles after btn_level rises -> press event, then repeat events (evt_repeat=1) 20 cycles after the press raise, then every 8 cycles. Release -> no more events, FSM IDLE.
- Fairness/backpressure: all four buttons rise the same cycle, evt_ready=0 for 5 cycles -> evt_id=0 held stable. Then ready=1 -> ids 1,2,3 on consecutive cycles, pointer=0 after.
- Merge: evt_ready=0 while btn[3] press is pending and a repeat fires -> a single event for id 3 with evt_repeat=0.
- Reset mid-operation: rst asserted in RPT with pend set -> next cycle all outputs 0. Button still held -> press event (evt_repeat=0) 1+DEB_CYCLES+2 cycles after rst deasserts.
